// File: rtl/reg_file_dump_reader_pkg.sv
// ----------------------------------------------------------------------------
// reg_file_dump_reader_pkg
// Shared widths, types and FSM state encodings for the register-file dump
// reader.
//   DUMP_XLEN    : width of one register / one dump beat
//   DUMP_ADDR_W  : register index width (x0..x31)
//   S_*          : FSM state encodings (2-bit)
// ----------------------------------------------------------------------------
package reg_file_dump_reader_pkg;

    localparam int DUMP_XLEN   = 32;
    localparam int DUMP_ADDR_W = 5;

    typedef logic [DUMP_ADDR_W-1:0] reg_addr_t;
    typedef logic [DUMP_XLEN-1:0]   word_t;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_SEND  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

endpackage

// File: rtl/reg_file_dump_reader.sv
// ----------------------------------------------------------------------------
// reg_file_dump_reader
// Walks a register-file address range on a start pulse, reading each register
// through one read port and streaming {addr, data} beats on a valid/ready
// interface. Used for debug dumps, end-of-test scoreboarding and checkpoints.
//
// Ports
//   clk, rst_n             clock, async active-low reset
//   start, abort           one-cycle request / synchronous cancel
//   first_addr, last_addr  inclusive range, captured on an accepted start
//   rd_addr, rd_data       register-file read port (combinational read)
//   busy                   read port borrowed (FETCH/SEND)
//   dump_valid/ready       beat handshake
//   dump_addr, dump_data   current beat
//   done                   one-cycle pulse after the last beat is accepted
//   err                    one-cycle pulse on a rejected start (first > last)
//
// State table
//   state  | meaning
//   IDLE   | waiting for start; read port released
//   FETCH  | drive rd_addr=ptr, capture rd_data into the beat buffer
//   SEND   | beat valid, held until accepted
//   DONE   | done pulse, back to IDLE
// ----------------------------------------------------------------------------
module reg_file_dump_reader
    import reg_file_dump_reader_pkg::*;
#(
    parameter int XLEN   = DUMP_XLEN,
    parameter int ADDR_W = DUMP_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [XLEN-1:0]   rd_data,
    output logic              busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [XLEN-1:0]   dump_data,
    output logic              done,
    output logic              err
);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] last;

    logic start_ok;
    logic start_bad;
    logic beat_taken;
    logic at_last;

    assign start_ok   = (state == S_IDLE) && start && (first_addr <= last_addr);
    assign start_bad  = (state == S_IDLE) && start && (first_addr >  last_addr);
    // abort wins over a same-cycle handshake, so it masks the advance
    assign beat_taken = (state == S_SEND) && dump_ready && !abort;
    assign at_last    = (ptr == last);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ok) state_nxt = S_FETCH;
            end
            S_FETCH: begin
                state_nxt = abort ? S_IDLE : S_SEND;
            end
            S_SEND: begin
                if (abort)
                    state_nxt = S_IDLE;
                else if (dump_ready)
                    state_nxt = at_last ? S_DONE : S_FETCH;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            ptr       <= '0;
            last      <= '0;
            dump_addr <= '0;
            dump_data <= '0;
            err       <= 1'b0;
        end else begin
            state <= state_nxt;
            err   <= start_bad;

            if (start_ok) begin
                ptr  <= first_addr;
                last <= last_addr;
            end

            // Snapshot: the beat keeps what the register held in its FETCH cycle
            if ((state == S_FETCH) && !abort) begin
                dump_addr <= ptr;
                dump_data <= rd_data;
            end

            // Never increments at the last address, so a range ending at 31
            // cannot wrap back to 0
            if (beat_taken && !at_last)
                ptr <= ptr + 1'b1;
        end
    end

    assign rd_addr    = (state == S_FETCH) ? ptr : '0;
    assign busy       = (state == S_FETCH) || (state == S_SEND);
    assign dump_valid = (state == S_SEND);
    assign done       = (state == S_DONE);

endmodule
